// File: rtl/vga_timing.sv
// vga_timing: 800x480 raster counters, syncs and display enable aligned with frame-buffer colour.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input that substitutes 64-pixel colour bars.
module vga_timing #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 40,
    parameter int H_SYNC        = 48,
    parameter int H_BACK        = 88,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 13,
    parameter int V_SYNC        = 3,
    parameter int V_BACK        = 32,
    parameter int HSYNC_POL     = 0,
    parameter int VSYNC_POL     = 0,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [2:0]  pixel_in,
    output logic [10:0] vga_h,
    output logic [10:0] vga_v,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [2:0]  rgb,
    output logic        frame_start
);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic        HS_ACT   = HSYNC_POL != 0;
    localparam logic        VS_ACT   = VSYNC_POL != 0;

    generate
        if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 8 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
            V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
            $error("vga_timing: illegal PIXEL_LATENCY or zero porch/sync width");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_h <= '0;
            vga_v <= '0;
        end else begin
            vga_h <= vga_h == H_LAST ? 11'd0 : vga_h + 11'd1;
            if (vga_h == H_LAST)
                vga_v <= vga_v == V_LAST ? 11'd0 : vga_v + 11'd1;
        end
    end

    logic de_raw, hs_raw, vs_raw;
    assign de_raw = vga_h < H_VIS && vga_v < V_VIS;
    assign hs_raw = vga_h >= HS_START && vga_h < HS_END;
    assign vs_raw = vga_v >= VS_START && vga_v < VS_END;
    assign frame_start = !reset && vga_h == 11'd0 && vga_v == 11'd0;

    // Each stage holds {de, hsync_active, vsync_active}; polarity is applied only at the pins.
    logic [2:0] line_sr [PIXEL_LATENCY];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) line_sr[i] <= 3'b000;
        end else begin
            line_sr[0] <= {de_raw, hs_raw, vs_raw};
            for (int i = 1; i < PIXEL_LATENCY; i++) line_sr[i] <= line_sr[i-1];
        end
    end

    logic [2:0] tail, colour;
    assign tail = line_sr[PIXEL_LATENCY-1];
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] pat_sr [PIXEL_LATENCY];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) pat_sr[i] <= 3'b000;
        end else begin
            pat_sr[0] <= vga_h[8:6];
            for (int i = 1; i < PIXEL_LATENCY; i++) pat_sr[i] <= pat_sr[i-1];
        end
    end
    assign colour = test_mode ? pat_sr[PIXEL_LATENCY-1] : pixel_in;
`else
    assign colour = pixel_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= !HS_ACT;
            vsync <= !VS_ACT;
            de    <= 1'b0;
            rgb   <= 3'b000;
        end else begin
            hsync <= tail[1] ? HS_ACT : !HS_ACT;
            vsync <= tail[0] ? VS_ACT : !VS_ACT;
            de    <= tail[2];
            rgb   <= tail[2] ? colour : 3'b000;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing at default timing plus a small-raster frame check.
module tb_vga_timing;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, test_mode, rst_s;
    logic [2:0]  pixel_in;
    logic [10:0] vga_h, vga_v, h_s, v_s;
    logic        hsync, vsync, de, fs, hs_s, vs_s, de_s, fs_s;
    logic [2:0]  rgb, rgb_s;

    vga_timing dut (
        .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pixel_in(pixel_in), .vga_h(vga_h), .vga_v(vga_v), .hsync(hsync), .vsync(vsync),
        .de(de), .rgb(rgb), .frame_start(fs)
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIXEL_LATENCY(1)
    ) dut_s (
        .clk(clk), .reset(rst_s),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pixel_in(3'b000), .vga_h(h_s), .vga_v(v_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .rgb(rgb_s), .frame_start(fs_s)
    );

    typedef struct { int n; logic rst; logic tm; } seg_t;
    typedef struct { int n; int h; int v; logic vs; logic fs; } spot_t;

    localparam logic [5:0] IDLE = 6'b110000;
    int passed = 0, total = 0;
    int hm, vm;
    logic [2:0] p1, p2;
    logic [5:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else passed++;
    endtask

    function automatic logic [5:0] expect_pins(input int h, input int v, input logic tm);
        logic d = h < 800 && v < 480;
        logic [2:0] c = tm ? 3'(h >> 6) : 3'(h + v);
        return {!(h >= 840 && h < 888), !(v >= 493 && v < 496), d, d ? c : 3'b000};
    endfunction

    task automatic step(input logic r, input logic tm);
        logic [5:0] e;
        reset = r;
        test_mode = tm;
        pixel_in = p2;
        #1;
        check("vga_h", 32'(vga_h), hm);
        check("vga_v", 32'(vga_v), vm);
        check("frame_start", 32'(fs), 32'(!r && hm == 0 && vm == 0));
        e = q.pop_front();
        check("pins{hs,vs,de,rgb}", 32'({hsync, vsync, de, rgb}), 32'(e));
        q.push_back(r ? IDLE : expect_pins(hm, vm, tm));
        if (r) q = '{IDLE, IDLE, IDLE};
        p2 = p1;
        p1 = 3'(hm + vm);
        @(posedge clk);
        if (r) begin
            hm = 0;
            vm = 0;
        end else if (hm == 975) begin
            hm = 0;
            vm = vm == 527 ? 0 : vm + 1;
        end else hm++;
        @(negedge clk);
    endtask

    initial begin
        seg_t segs[6];
        spot_t spots[10];
        int k, fsc, vsl;
        segs = '{'{5, 1'b1, 1'b0}, '{976 * 2 + 400, 1'b0, 1'b0}, '{1, 1'b1, 1'b0},
                 '{1200, 1'b0, 1'b0}, '{1, 1'b1, 1'b1}, '{1000, 1'b0, 1'b1}};
        spots = '{'{0, 0, 0, 1'b1, 1'b1}, '{13, 13, 0, 1'b1, 1'b0}, '{14, 0, 1, 1'b1, 1'b0},
                  '{99, 1, 7, 1'b1, 1'b0}, '{100, 2, 7, 1'b0, 1'b0}, '{127, 1, 9, 1'b0, 1'b0},
                  '{128, 2, 9, 1'b1, 1'b0}, '{139, 13, 9, 1'b1, 1'b0}, '{140, 0, 0, 1'b1, 1'b1},
                  '{280, 0, 0, 1'b1, 1'b1}};
        reset = 1'b1;
        rst_s = 1'b1;
        test_mode = 1'b0;
        pixel_in = 3'b000;
        p1 = 3'b000;
        p2 = 3'b000;
        hm = 0;
        vm = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q = '{IDLE, IDLE, IDLE};
        foreach (segs[s])
            for (int j = 0; j < segs[s].n; j++)
`ifdef VGA_TEST_PATTERN_EN
                step(segs[s].rst, segs[s].tm);
`else
                step(segs[s].rst, 1'b0);
`endif
        reset = 1'b1;
        rst_s = 1'b0;
        k = 0;
        fsc = 0;
        vsl = 0;
        for (int n = 0; n < 282; n++) begin
            #1;
            if (k < 10 && spots[k].n == n) begin
                check("small vga_h", 32'(h_s), spots[k].h);
                check("small vga_v", 32'(v_s), spots[k].v);
                check("small vsync", 32'(vs_s), 32'(spots[k].vs));
                check("small frame_start", 32'(fs_s), 32'(spots[k].fs));
                k++;
            end
            if (n < 280 && fs_s) fsc++;
            if (!vs_s) vsl++;
            @(negedge clk);
        end
        check("small frame_start pulses", fsc, 2);
        check("small vsync low clocks", vsl, 56);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
